// File: rtl/kernel_launcher.sv
// -----------------------------------------------------------------------------
// kernel_launcher
//   Host-side sequencer that sits directly in front of the kernel top wrapper.
//   It accepts one command asking for N back-to-back kernel runs, issues exactly
//   one ap_start per run, and returns each run's out0 value together with the
//   number of RUN cycles it took as a single handshaked result.
//
//   Optional build macro: LAUNCHER_TIMEOUT_EN
//     When defined, a watchdog ends a run after TIMEOUT_CYCLES RUN cycles
//     without ap_done. It then returns an error result and finishes the command.
//     When undefined, there is no watchdog, result_err is tied to 0 and
//     TIMEOUT_CYCLES has no effect.
//
// Ports
//   clk            clock, all logic on the rising edge
//   rst            synchronous reset, active-low
//   cmd_valid      host requests a run sequence
//   cmd_ready      launcher can accept a command (IDLE)
//   cmd_runs       number of runs; 0 is treated as 1
//   ap_start       start request to the kernel wrapper
//   ap_ready       kernel can latch a start
//   ap_done        kernel finished (one-cycle pulse)
//   out0           kernel return value, valid while ap_done is high
//   result_valid   result available
//   result_ready   host consumes the result
//   result_data    out0 captured at ap_done
//   result_cycles  RUN-state cycles for this run
//   result_err     watchdog expired; result_data is not meaningful
//   result_last    final result of the command
//   busy           launcher is not IDLE
// -----------------------------------------------------------------------------
module kernel_launcher #(
  parameter int DATA_WIDTH     = 8,
  parameter int CNT_WIDTH      = 32,
  parameter int RUNS_WIDTH     = 8,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [RUNS_WIDTH-1:0] cmd_runs,
  output logic                  ap_start,
  input  logic                  ap_ready,
  input  logic                  ap_done,
  input  logic [DATA_WIDTH-1:0] out0,
  output logic                  result_valid,
  input  logic                  result_ready,
  output logic [DATA_WIDTH-1:0] result_data,
  output logic [CNT_WIDTH-1:0]  result_cycles,
  output logic                  result_err,
  output logic                  result_last,
  output logic                  busy
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    START  = 2'd1,
    RUN    = 2'd2,
    RESULT = 2'd3
  } state_t;

  state_t                state;
  state_t                state_next;
  logic [RUNS_WIDTH-1:0] runs_left;
  logic [CNT_WIDTH-1:0]  cycle_cnt;
  logic [CNT_WIDTH-1:0]  cnt_inc;
  logic                  timeout_hit;

  // Saturating increment: the count sticks at all-ones instead of wrapping.
  assign cnt_inc = (&cycle_cnt) ? cycle_cnt : cycle_cnt + CNT_WIDTH'(1);

`ifdef LAUNCHER_TIMEOUT_EN
  localparam logic [CNT_WIDTH-1:0] TIMEOUT_LIMIT = CNT_WIDTH'(TIMEOUT_CYCLES);

  // Expiry is judged on the count this RUN cycle would reach, so the run that
  // times out reports exactly TIMEOUT_CYCLES. ap_done in the same cycle wins.
  assign timeout_hit = (state == RUN) && !ap_done && (cnt_inc >= TIMEOUT_LIMIT);
`else
  assign timeout_hit = 1'b0;
  assign result_err  = 1'b0;
`endif

  // Handshake-visible outputs are pure functions of the state.
  assign cmd_ready    = (state == IDLE);
  assign ap_start     = (state == START);
  assign result_valid = (state == RESULT);
  assign busy         = (state != IDLE);

  // NOTE: clocked state uses non-blocking assignments so every register sees
  // the pre-edge values of the others, independent of statement order.
  always_ff @(posedge clk) begin
    if (!rst) state <= IDLE;
    else      state <= state_next;
  end

  // NOTE: state_next gets a default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:   if (cmd_valid) state_next = START;
      START:  if (ap_ready) state_next = RUN;
      RUN:    if (ap_done || timeout_hit) state_next = RESULT;
      RESULT: if (result_ready) state_next = (result_last || result_err) ? IDLE : START;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      runs_left     <= '0;
      cycle_cnt     <= '0;
      result_data   <= '0;
      result_cycles <= '0;
      result_last   <= 1'b0;
`ifdef LAUNCHER_TIMEOUT_EN
      result_err    <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (cmd_valid) runs_left <= (cmd_runs == '0) ? RUNS_WIDTH'(1) : cmd_runs;
        end
        START: begin
          if (ap_ready) cycle_cnt <= '0;
        end
        RUN: begin
          cycle_cnt <= cnt_inc;
          if (ap_done) begin
            result_data   <= out0;
            result_cycles <= cnt_inc;
            result_last   <= (runs_left == RUNS_WIDTH'(1));
            runs_left     <= runs_left - RUNS_WIDTH'(1);
`ifdef LAUNCHER_TIMEOUT_EN
            result_err    <= 1'b0;
          end else if (timeout_hit) begin
            // The kernel keeps running; the command is abandoned.
            result_data   <= '0;
            result_cycles <= TIMEOUT_LIMIT;
            result_last   <= 1'b1;
            result_err    <= 1'b1;
`endif
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_kernel_launcher.sv
// -----------------------------------------------------------------------------
// tb_kernel_launcher
//   Directed bench for kernel_launcher. Inputs are driven and outputs sampled on
//   the falling edge; the DUT acts on the rising edge. The watchdog section is
//   compiled only when LAUNCHER_TIMEOUT_EN is defined.
// -----------------------------------------------------------------------------
module tb_kernel_launcher;

  localparam int DW = 8;
  localparam int CW = 32;
  localparam int RW = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          cmd_valid;
  logic          cmd_ready;
  logic [RW-1:0] cmd_runs;
  logic          ap_start;
  logic          ap_ready;
  logic          ap_done;
  logic [DW-1:0] out0;
  logic          result_valid;
  logic          result_ready;
  logic [DW-1:0] result_data;
  logic [CW-1:0] result_cycles;
  logic          result_err;
  logic          result_last;
  logic          busy;

  int checks = 0;
  int errors = 0;

  // Protocol monitors, sampled at the active edge.
  int launches     = 0;
  int start_cycles = 0;
  int overlap      = 0;

  kernel_launcher #(
    .DATA_WIDTH    (DW),
    .CNT_WIDTH     (CW),
    .RUNS_WIDTH    (RW),
    .TIMEOUT_CYCLES(16)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .cmd_valid    (cmd_valid),
    .cmd_ready    (cmd_ready),
    .cmd_runs     (cmd_runs),
    .ap_start     (ap_start),
    .ap_ready     (ap_ready),
    .ap_done      (ap_done),
    .out0         (out0),
    .result_valid (result_valid),
    .result_ready (result_ready),
    .result_data  (result_data),
    .result_cycles(result_cycles),
    .result_err   (result_err),
    .result_last  (result_last),
    .busy         (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (ap_start) start_cycles++;
    if (ap_start && ap_ready) launches++;
    if (ap_start && result_valid) overlap++;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  // Called at the falling edge right after the launch edge (state is RUN).
  // Pulses ap_done in the lat-th RUN cycle.
  task automatic run_kernel(input int lat, input logic [DW-1:0] val);
    repeat (lat - 1) step();
    ap_done = 1'b1;
    out0    = val;
    step();
    ap_done = 1'b0;
    out0    = '0;
  endtask

  task automatic check_result(input string tag, input logic [DW-1:0] d,
                              input logic [CW-1:0] cyc, input logic last, input logic err);
    check({tag, ".valid"},  result_valid,  1'b1);
    check({tag, ".data"},   result_data,   d);
    check({tag, ".cycles"}, result_cycles, cyc);
    check({tag, ".last"},   result_last,   last);
    check({tag, ".err"},    result_err,    err);
    check({tag, ".start"},  ap_start,      1'b0);
  endtask

  task automatic consume();
    result_ready = 1'b1;
    step();
    result_ready = 1'b0;
  endtask

  initial begin
    int l0;
    int s0;

    rst = 1'b0; cmd_valid = 1'b0; cmd_runs = '0; ap_ready = 1'b0;
    ap_done = 1'b0; out0 = '0; result_ready = 1'b0;

    // ---------------- reset ----------------
    repeat (3) step();
    check("rst.cmd_ready", cmd_ready,     1'b1);
    check("rst.busy",      busy,          1'b0);
    check("rst.ap_start",  ap_start,      1'b0);
    check("rst.valid",     result_valid,  1'b0);
    check("rst.data",      result_data,   '0);
    check("rst.cycles",    result_cycles, '0);
    check("rst.err",       result_err,    1'b0);
    check("rst.last",      result_last,   1'b0);
    rst = 1'b1;
    step();
    check("idle.cmd_ready", cmd_ready, 1'b1);

    // ---------------- single run ----------------
    l0 = launches; s0 = start_cycles;
    cmd_valid = 1'b1; cmd_runs = 8'd1; ap_ready = 1'b1;
    step();
    cmd_valid = 1'b0;
    check("single.start",     ap_start,  1'b1);
    check("single.cmd_ready", cmd_ready, 1'b0);
    check("single.busy",      busy,      1'b1);
    step();
    check("single.start_drop", ap_start, 1'b0);
    run_kernel(5, 8'h2A);
    check_result("single", 8'h2A, 32'd5, 1'b1, 1'b0);
    consume();
    check("single.idle",     cmd_ready,          1'b1);
    check("single.nvalid",   result_valid,       1'b0);
    check("single.launches", launches - l0,      1);
    check("single.start_cy", start_cycles - s0,  1);

    // ---------------- three runs with backpressure ----------------
    l0 = launches;
    cmd_valid = 1'b1; cmd_runs = 8'd3;
    step();
    cmd_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check($sformatf("multi%0d.start", i), ap_start, 1'b1);
      step();
      // A command offered mid-sequence must be refused.
      cmd_valid = 1'b1; cmd_runs = 8'd9;
      run_kernel(2 + i, DW'(8'h10 + i));
      check($sformatf("multi%0d.cmd_ready", i), cmd_ready, 1'b0);
      cmd_valid = 1'b0;
      check_result($sformatf("multi%0d", i), DW'(8'h10 + i), CW'(2 + i), i == 2, 1'b0);
      repeat (4) begin
        step();
        check($sformatf("multi%0d.hold_v", i), result_valid, 1'b1);
        check($sformatf("multi%0d.hold_d", i), result_data,  DW'(8'h10 + i));
        check($sformatf("multi%0d.hold_s", i), ap_start,     1'b0);
      end
      consume();
      check($sformatf("multi%0d.next_start", i), ap_start, (i < 2) ? 1'b1 : 1'b0);
    end
    check("multi.idle",     cmd_ready,     1'b1);
    check("multi.launches", launches - l0, 3);

    // ---------------- cmd_runs=0 with ap_ready held low ----------------
    l0 = launches; s0 = start_cycles;
    cmd_valid = 1'b1; cmd_runs = 8'd0; ap_ready = 1'b0;
    step();
    cmd_valid = 1'b0;
    repeat (10) begin
      check("zero.hold_start", ap_start, 1'b1);
      step();
    end
    check("zero.no_launch", launches - l0, 0);
    ap_ready = 1'b1;
    step();
    run_kernel(1, 8'h5C);
    check_result("zero", 8'h5C, 32'd1, 1'b1, 1'b0);
    consume();
    check("zero.idle",     cmd_ready,         1'b1);
    check("zero.launches", launches - l0,     1);
    check("zero.start_cy", start_cycles - s0, 11);

`ifdef LAUNCHER_TIMEOUT_EN
    // ---------------- watchdog: no ap_done ----------------
    cmd_valid = 1'b1; cmd_runs = 8'd4;
    step();
    cmd_valid = 1'b0;
    step();
    repeat (15) step();
    check("wd.not_yet", result_valid, 1'b0);
    step();
    check_result("wd", 8'h00, 32'd16, 1'b1, 1'b1);
    consume();
    check("wd.idle", cmd_ready, 1'b1);

    // ---------------- watchdog: ap_done on the expiry cycle ----------------
    cmd_valid = 1'b1; cmd_runs = 8'd1;
    step();
    cmd_valid = 1'b0;
    step();
    run_kernel(16, 8'h77);
    check_result("wd_done", 8'h77, 32'd16, 1'b1, 1'b0);
    consume();
`else
    // ---------------- long run, no watchdog ----------------
    cmd_valid = 1'b1; cmd_runs = 8'd1;
    step();
    cmd_valid = 1'b0;
    step();
    run_kernel(20, 8'h77);
    check_result("long", 8'h77, 32'd20, 1'b1, 1'b0);
    consume();
`endif

    // ---------------- reset mid-RUN ----------------
    cmd_valid = 1'b1; cmd_runs = 8'd2;
    step();
    cmd_valid = 1'b0;
    step();
    repeat (2) step();
    rst = 1'b0;
    step();
    rst = 1'b1;
    check("rst_run.start",  ap_start,      1'b0);
    check("rst_run.valid",  result_valid,  1'b0);
    check("rst_run.idle",   cmd_ready,     1'b1);
    check("rst_run.busy",   busy,          1'b0);
    check("rst_run.cycles", result_cycles, '0);

    // ---------------- reset mid-RESULT ----------------
    cmd_valid = 1'b1; cmd_runs = 8'd2;
    step();
    cmd_valid = 1'b0;
    step();
    run_kernel(3, 8'h99);
    check_result("pre_rst", 8'h99, 32'd3, 1'b0, 1'b0);
    rst = 1'b0;
    step();
    rst = 1'b1;
    check("rst_res.valid", result_valid, 1'b0);
    check("rst_res.start", ap_start,     1'b0);
    check("rst_res.data",  result_data,  '0);
    check("rst_res.last",  result_last,  1'b0);
    check("rst_res.idle",  cmd_ready,    1'b1);
    step();
    check("rst_res.stay_idle", busy, 1'b0);

    check("no_start_during_result", overlap, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
